// File: rtl/fu_wb_arbiter_pkg.sv
// Shared types and helpers for the FU write-back arbiter and ROB/LSU squash logic.
package fu_wb_arbiter_pkg;

    localparam int unsigned NB_WB_SRC   = 5;
    localparam int unsigned NB_WB_PORTS = 2;
    localparam int unsigned WB_DEPTH    = 4;
    localparam int unsigned WB_ID_W     = 6;
    localparam int unsigned WB_DATA_W   = 64;
    localparam int unsigned WB_SRC_W    = $clog2(NB_WB_SRC);

    typedef logic [WB_ID_W-1:0]  rob_id_t;
    typedef logic [WB_SRC_W-1:0] wb_src_idx_t;

    typedef struct packed {
        rob_id_t               id;
        logic [WB_DATA_W-1:0]  data;
        logic                  rd_we;
    } wb_result_t;

    localparam int unsigned WB_RES_W = $bits(wb_result_t);

    // Distance from the oldest in-flight instruction; modular so ids may wrap.
    function automatic rob_id_t rob_age(rob_id_t id, rob_id_t head);
        return id - head;
    endfunction

    // An instruction dies when it is strictly younger than the squash point.
    function automatic logic rob_killed(logic sq_valid, rob_id_t id, rob_id_t sq_id,
                                        rob_id_t head);
        return sq_valid && (rob_age(id, head) > rob_age(sq_id, head));
    endfunction

endpackage

// File: rtl/fu_wb_arbiter_fifo.sv
// Per-source result buffer: DEPTH entries of {live, result}, in-place squash kill.
module fu_wb_fifo
    import fu_wb_arbiter_pkg::*;
#(
    parameter int unsigned DEPTH = WB_DEPTH
) (
    input  logic                       clk,
    input  logic                       rstn,
    input  logic                       push_i,
    input  logic [WB_RES_W-1:0]        push_data_i,
    input  logic                       pop_i,
    input  logic                       squash_valid_i,
    input  logic [WB_ID_W-1:0]         squash_id_i,
    input  logic [WB_ID_W-1:0]         rob_head_i,
    output logic [WB_RES_W-1:0]        head_o,
    output logic                       head_live_o,
    output logic [$clog2(DEPTH):0]     count_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    wb_result_t         mem_q [DEPTH];
    logic [DEPTH-1:0]   live_q;
    logic [DEPTH-1:0]   kill_mask;
    logic [PTR_W-1:0]   wr_q, rd_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               do_pop;

    // Entries younger than the squash point lose their live bit at the edge.
    always_comb begin
        kill_mask = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            kill_mask[i] = rob_killed(squash_valid_i, mem_q[i].id, squash_id_i, rob_head_i);
        end
        do_pop = pop_i && (cnt_q != '0);
    end

    // Pointer, count and live-bit state; a fresh push overrides the kill of its slot.
    always_ff @(posedge clk) begin
        if (rstn) begin
            wr_q   <= '0;
            rd_q   <= '0;
            cnt_q  <= '0;
            live_q <= '0;
        end else begin
            live_q <= live_q & ~kill_mask;
            if (push_i) begin
                live_q[wr_q] <= 1'b1;
                wr_q         <= wr_q + 1'b1;
            end
            if (do_pop) begin
                rd_q <= rd_q + 1'b1;
            end
            cnt_q <= cnt_q + CNT_W'(push_i) - CNT_W'(do_pop);
        end
    end

    // Payload storage needs no reset; the live bits qualify it.
    always_ff @(posedge clk) begin
        if (push_i) begin
            mem_q[wr_q] <= wb_result_t'(push_data_i);
        end
    end

    assign head_o      = mem_q[rd_q];
    assign head_live_o = live_q[rd_q];
    assign count_o     = cnt_q;

endmodule

// File: rtl/fu_wb_arbiter.sv
// Round-robin write-back arbiter: NB_SRC buffered FU result streams onto NB_WB ports.
module fu_wb_arbiter
    import fu_wb_arbiter_pkg::*;
#(
    parameter int unsigned NB_SRC = NB_WB_SRC,
    parameter int unsigned NB_WB  = NB_WB_PORTS,
    parameter int unsigned DEPTH  = WB_DEPTH
) (
    input  logic                              clk,
    input  logic                              rstn,
    input  logic [NB_SRC-1:0]                 src_valid_i,
    output logic [NB_SRC-1:0]                 src_ready_o,
    input  logic [NB_SRC*WB_ID_W-1:0]         src_id_i,
    input  logic [NB_SRC*WB_DATA_W-1:0]       src_data_i,
    input  logic [NB_SRC-1:0]                 src_rd_we_i,
    output logic [NB_WB-1:0]                  wb_valid_o,
    output logic [NB_WB*WB_ID_W-1:0]          wb_id_o,
    output logic [NB_WB*WB_DATA_W-1:0]        wb_data_o,
    output logic [NB_WB-1:0]                  wb_rd_we_o,
    output logic [NB_WB*$clog2(NB_SRC)-1:0]   wb_src_o,
    input  logic [WB_ID_W-1:0]                rob_head_i,
    input  logic                              squash_valid_i,
    input  logic [WB_ID_W-1:0]                squash_id_i
);

    localparam int unsigned ID_W   = WB_ID_W;
    localparam int unsigned DATA_W = WB_DATA_W;
    localparam int unsigned SRC_W  = $clog2(NB_SRC);
    localparam int unsigned CNT_W  = $clog2(DEPTH) + 1;

    wb_result_t         head [NB_SRC];
    logic [CNT_W-1:0]   count [NB_SRC];
    logic [NB_SRC-1:0]  head_live, nonempty, eligible, grant, pop, push;
    int unsigned        pos  [NB_SRC];
    int unsigned        rank [NB_SRC];
    logic [SRC_W-1:0]   rr_q, rr_d;

    for (genvar g = 0; g < NB_SRC; g++) begin : g_fifo
        fu_wb_fifo #(
            .DEPTH (DEPTH)
        ) u_fifo (
            .clk            (clk),
            .rstn           (rstn),
            .push_i         (push[g]),
            .push_data_i    ({src_id_i[g*ID_W +: ID_W], src_data_i[g*DATA_W +: DATA_W],
                              src_rd_we_i[g]}),
            .pop_i          (pop[g]),
            .squash_valid_i (squash_valid_i),
            .squash_id_i    (squash_id_i),
            .rob_head_i     (rob_head_i),
            .head_o         (head[g]),
            .head_live_o    (head_live[g]),
            .count_o        (count[g])
        );
    end

    // Per-source handshake and eligibility; killed pushes are accepted but dropped.
    always_comb begin
        for (int unsigned s = 0; s < NB_SRC; s++) begin
            nonempty[s]    = count[s] != '0;
            src_ready_o[s] = count[s] < CNT_W'(DEPTH);
            eligible[s]    = nonempty[s] && head_live[s] &&
                             !rob_killed(squash_valid_i, head[s].id, squash_id_i, rob_head_i);
            push[s]        = src_valid_i[s] && src_ready_o[s] &&
                             !rob_killed(squash_valid_i, src_id_i[s*ID_W +: ID_W], squash_id_i,
                                         rob_head_i);
        end
    end

    // Rank each eligible head by scan order from rr_q; the first NB_WB ranks win a port.
    always_comb begin
        logic        any;
        int unsigned best;
        int unsigned last;
        any  = 1'b0;
        best = 0;
        last = 0;
        rr_d = rr_q;
        for (int unsigned s = 0; s < NB_SRC; s++) begin
            pos[s] = (NB_SRC + s - 32'(rr_q)) % NB_SRC;
        end
        for (int unsigned s = 0; s < NB_SRC; s++) begin
            rank[s] = 0;
            for (int unsigned t = 0; t < NB_SRC; t++) begin
                if (eligible[t] && pos[t] < pos[s]) begin
                    rank[s] = rank[s] + 1;
                end
            end
        end
        for (int unsigned s = 0; s < NB_SRC; s++) begin
            grant[s] = eligible[s] && (rank[s] < NB_WB);
            // Dead heads drain without a port.
            pop[s]   = grant[s] || (nonempty[s] && !head_live[s]);
            if (grant[s] && (!any || pos[s] > best)) begin
                any  = 1'b1;
                best = pos[s];
                last = s;
            end
        end
        if (any) begin
            rr_d = SRC_W'((last + 1) % NB_SRC);
        end
    end

    // Steer granted heads onto ports in rank order; idle ports drive zeros.
    always_comb begin
        wb_valid_o = '0;
        wb_id_o    = '0;
        wb_data_o  = '0;
        wb_rd_we_o = '0;
        wb_src_o   = '0;
        for (int unsigned p = 0; p < NB_WB; p++) begin
            for (int unsigned s = 0; s < NB_SRC; s++) begin
                if (grant[s] && rank[s] == p) begin
                    wb_valid_o[p]                  = 1'b1;
                    wb_id_o[p*ID_W +: ID_W]        = head[s].id;
                    wb_data_o[p*DATA_W +: DATA_W]  = head[s].data;
                    wb_rd_we_o[p]                  = head[s].rd_we;
                    wb_src_o[p*SRC_W +: SRC_W]     = SRC_W'(s);
                end
            end
        end
    end

    // Round-robin pointer advances past the last granted source.
    always_ff @(posedge clk) begin
        if (rstn) begin
            rr_q <= '0;
        end else begin
            rr_q <= rr_d;
        end
    end

    for (genvar s = 0; s < NB_SRC; s++) begin : g_chk_push
        a_push_full: assert property (@(posedge clk) disable iff (rstn)
            !(src_valid_i[s] && !src_ready_o[s]))
            else $error("src %0d valid while buffer full", s);
    end

    for (genvar p = 0; p < NB_WB; p++) begin : g_chk_port
        a_wb_killed: assert property (@(posedge clk) disable iff (rstn)
            !(wb_valid_o[p] && rob_killed(squash_valid_i, wb_id_o[p*ID_W +: ID_W],
                                          squash_id_i, rob_head_i)))
            else $error("port %0d carries a squashed id", p);
        for (genvar q = p + 1; q < NB_WB; q++) begin : g_pair
            a_dup_src: assert property (@(posedge clk) disable iff (rstn)
                !(wb_valid_o[p] && wb_valid_o[q] &&
                  wb_src_o[p*SRC_W +: SRC_W] == wb_src_o[q*SRC_W +: SRC_W]))
                else $error("ports %0d and %0d granted the same source", p, q);
        end
    end

endmodule
